// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester slice.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB bus signals seen by the requester and its peers.
interface apb_master_if import apb_pkg::*; #(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states; expired flags the last cycle allowed before abort.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  // Saturates at TIMEOUT-1 so the count can never wrap back to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: accepts one command, runs SETUP/ACCESS, returns a one-cycle response.
module apb_master import apb_pkg::*; #(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input logic          pclk,
  input logic          preset,
  apb_master_if.master bus
);

  apb_state_e        r_state;
  apb_state_e        w_nextState;
  logic              r_cmdReady;
  logic              r_psel, r_penable, r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rspValid, r_rspErr, r_rspTimeout;
  logic [DATA_W-1:0] r_rspRdata;

  logic              w_psel, w_penable, w_pwrite;
  logic [ADDR_W-1:0] w_paddr;
  logic [DATA_W-1:0] w_pwdata;
  logic              w_rspValid, w_rspErr, w_rspTimeout;
  logic [DATA_W-1:0] w_rspRdata;
  logic              w_timerClear, w_timerInc, w_timerExpired;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_waitTimer (
    .i_clk     (pclk),
    .i_rst     (preset),
    .i_clear   (w_timerClear),
    .i_inc     (w_timerInc),
    .o_expired (w_timerExpired)
  );

  // Every output is registered, so this block computes the values for the next cycle.
  always_comb begin
    w_nextState  = r_state;
    w_psel       = 1'b0;
    w_penable    = 1'b0;
    w_pwrite     = r_pwrite;
    w_paddr      = r_paddr;
    w_pwdata     = r_pwdata;
    w_rspValid   = 1'b0;
    w_rspErr     = 1'b0;
    w_rspTimeout = 1'b0;
    w_rspRdata   = '0;
    w_timerClear = 1'b0;
    w_timerInc   = 1'b0;
    case (r_state)
      APB_IDLE: begin
        if (bus.cmd_valid && r_cmdReady) begin
          w_pwrite    = bus.cmd_write;
          w_paddr     = bus.cmd_addr;
          w_pwdata    = bus.cmd_wdata;
          w_psel      = 1'b1;
          w_nextState = APB_SETUP;
        end
      end
      APB_SETUP: begin
        w_psel       = 1'b1;
        w_penable    = 1'b1;
        w_timerClear = 1'b1;
        w_nextState  = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (bus.pready) begin
          w_rspValid  = 1'b1;
          w_rspErr    = bus.pslverr;
          w_rspRdata  = (!r_pwrite && !bus.pslverr) ? bus.prdata : '0;
          w_nextState = APB_IDLE;
        end else if (w_timerExpired) begin
          w_rspValid   = 1'b1;
          w_rspErr     = 1'b1;
          w_rspTimeout = 1'b1;
          w_nextState  = APB_IDLE;
        end else begin
          w_psel     = 1'b1;
          w_penable  = 1'b1;
          w_timerInc = 1'b1;
        end
      end
      default: begin
        w_nextState = APB_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state      <= APB_IDLE;
      r_cmdReady   <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rspValid   <= 1'b0;
      r_rspErr     <= 1'b0;
      r_rspTimeout <= 1'b0;
      r_rspRdata   <= '0;
    end else begin
      r_state      <= w_nextState;
      r_cmdReady   <= (w_nextState == APB_IDLE);
      r_psel       <= w_psel;
      r_penable    <= w_penable;
      r_pwrite     <= w_pwrite;
      r_paddr      <= w_paddr;
      r_pwdata     <= w_pwdata;
      r_rspValid   <= w_rspValid;
      r_rspErr     <= w_rspErr;
      r_rspTimeout <= w_rspTimeout;
      r_rspRdata   <= w_rspRdata;
    end
  end

  assign bus.cmd_ready   = r_cmdReady;
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;
  assign bus.rsp_valid   = r_rspValid;
  assign bus.rsp_err     = r_rspErr;
  assign bus.rsp_timeout = r_rspTimeout;
  assign bus.rsp_rdata   = r_rspRdata;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table, random transfers
// against a transfer-level reference model, and reset corner cases.
module tb_apb_master;
  import apb_pkg::*;

  localparam int TIMEOUT = 16;

  logic pclk = 1'b0;
  logic preset;

  apb_master_if #(.ADDR_W(APB_ADDR_W), .DATA_W(APB_DATA_W)) bus ();

  apb_master #(.ADDR_W(APB_ADDR_W), .DATA_W(APB_DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slvErr;
    int          waitCycles;
    logic [31:0] expRdata;
    logic        expErr;
    logic        expTimeout;
    int          expAccess;
  } vector_t;

  typedef struct {
    logic        gotRsp;
    int          pselStart;
    int          penableStart;
    int          rspTime;
    int          accessCount;
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
    logic        pselAtRsp;
    logic        penableAtRsp;
    logic        readyAtRsp;
    logic        oneCycle;
    logic        addrStable;
    logic        dataStable;
    logic        writeStable;
    logic        quiet;
  } result_t;

  function automatic vector_t mkVec(logic write, logic [31:0] addr, logic [31:0] wdata,
                                    logic [31:0] prdata, logic slvErr, int waitCycles,
                                    logic [31:0] expRdata, logic expErr, logic expTimeout,
                                    int expAccess);
    vector_t v;
    v.write = write; v.addr = addr; v.wdata = wdata; v.prdata = prdata;
    v.slvErr = slvErr; v.waitCycles = waitCycles; v.expRdata = expRdata;
    v.expErr = expErr; v.expTimeout = expTimeout; v.expAccess = expAccess;
    return v;
  endfunction

  // Transfer-level reference: the slave stalls for waitCycles ACCESS cycles, and
  // the requester gives up after TIMEOUT stalled cycles.
  function automatic vector_t modelExpect(vector_t v);
    vector_t e = v;
    if (v.waitCycles >= TIMEOUT) begin
      e.expTimeout = 1'b1;
      e.expErr     = 1'b1;
      e.expRdata   = 32'h0;
      e.expAccess  = TIMEOUT;
    end else begin
      e.expTimeout = 1'b0;
      e.expErr     = v.slvErr;
      e.expRdata   = (!v.write && !v.slvErr) ? v.prdata : 32'h0;
      e.expAccess  = v.waitCycles + 1;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Offers the command, then plays the slave cycle by cycle, observing at negedges.
  task automatic applyStimulus(input vector_t v, output result_t r);
    int waitT;
    int accessSeen;
    r = '{default: 0};
    r.addrStable  = 1'b1;
    r.dataStable  = 1'b1;
    r.writeStable = 1'b1;
    r.quiet       = 1'b1;
    accessSeen    = 0;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_valid = 1'b1;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'($urandom_range(0, 1));
    bus.prdata    = $urandom();
    waitT = 0;
    while (bus.cmd_ready !== 1'b1 && waitT < 20) begin
      @(negedge pclk);
      waitT++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      checkOutput("cmdReadyWait", {63'h0, bus.cmd_ready}, 64'h1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(negedge pclk);
    for (int t = 1; t <= TIMEOUT + 8 && !r.gotRsp; t++) begin
      if (bus.psel === 1'b1 && r.pselStart == 0) r.pselStart = t;
      if (bus.penable === 1'b1 && r.penableStart == 0) r.penableStart = t;
      if (bus.psel === 1'b1) begin
        if (bus.paddr !== v.addr)   r.addrStable  = 1'b0;
        if (bus.pwdata !== v.wdata) r.dataStable  = 1'b0;
        if (bus.pwrite !== v.write) r.writeStable = 1'b0;
      end
      if (bus.penable === 1'b1) r.accessCount++;
      if (bus.rsp_valid === 1'b1) begin
        r.gotRsp       = 1'b1;
        r.rspTime      = t;
        r.rdata        = bus.rsp_rdata;
        r.err          = bus.rsp_err;
        r.timeout      = bus.rsp_timeout;
        r.pselAtRsp    = bus.psel;
        r.penableAtRsp = bus.penable;
        r.readyAtRsp   = bus.cmd_ready;
      end else if (bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
        r.quiet = 1'b0;
      end
      if (bus.cmd_ready === 1'b1) begin
        bus.cmd_valid = 1'b0;
      end else begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = $urandom();
        bus.cmd_wdata = $urandom();
      end
      if (bus.penable === 1'b1) begin
        if (accessSeen >= v.waitCycles) begin
          bus.pready  = 1'b1;
          bus.prdata  = v.prdata;
          bus.pslverr = v.slvErr;
        end else begin
          bus.pready  = 1'b0;
          bus.prdata  = $urandom();
          bus.pslverr = 1'($urandom_range(0, 1));
        end
        accessSeen++;
      end else begin
        bus.pready  = 1'($urandom_range(0, 1));
        bus.prdata  = $urandom();
        bus.pslverr = 1'($urandom_range(0, 1));
      end
      @(negedge pclk);
    end
    r.oneCycle = (bus.rsp_valid === 1'b0);
    bus.pready = 1'b0;
  endtask

  task automatic checkResult(input string tag, input vector_t v, input result_t r);
    checkOutput({tag, ".gotRsp"},       {63'h0, r.gotRsp}, 64'h1);
    checkOutput({tag, ".pselStart"},    64'(r.pselStart), 64'd1);
    checkOutput({tag, ".penableStart"}, 64'(r.penableStart), 64'd2);
    checkOutput({tag, ".accessCycles"}, 64'(r.accessCount), 64'(v.expAccess));
    checkOutput({tag, ".rspTime"},      64'(r.rspTime), 64'(v.expAccess + 2));
    checkOutput({tag, ".rdata"},        {32'h0, r.rdata}, {32'h0, v.expRdata});
    checkOutput({tag, ".err"},          {63'h0, r.err}, {63'h0, v.expErr});
    checkOutput({tag, ".timeout"},      {63'h0, r.timeout}, {63'h0, v.expTimeout});
    checkOutput({tag, ".pselAtRsp"},    {63'h0, r.pselAtRsp}, 64'h0);
    checkOutput({tag, ".penableAtRsp"}, {63'h0, r.penableAtRsp}, 64'h0);
    checkOutput({tag, ".readyAtRsp"},   {63'h0, r.readyAtRsp}, 64'h1);
    checkOutput({tag, ".rspOneCycle"},  {63'h0, r.oneCycle}, 64'h1);
    checkOutput({tag, ".addrStable"},   {63'h0, r.addrStable}, 64'h1);
    checkOutput({tag, ".wdataStable"},  {63'h0, r.dataStable}, 64'h1);
    checkOutput({tag, ".writeStable"},  {63'h0, r.writeStable}, 64'h1);
    checkOutput({tag, ".rspQuiet"},     {63'h0, r.quiet}, 64'h1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".flags"},
                {58'h0, bus.cmd_ready, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid,
                 bus.rsp_err | bus.rsp_timeout}, 64'h0);
    checkOutput({tag, ".paddr"},  {32'h0, bus.paddr}, 64'h0);
    checkOutput({tag, ".pwdata"}, {32'h0, bus.pwdata}, 64'h0);
    checkOutput({tag, ".rdata"},  {32'h0, bus.rsp_rdata}, 64'h0);
  endtask

  vector_t vectors[8];
  vector_t rv;
  result_t res;
  int      rspCount;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors[0] = mkVec(1'b1, 32'd5,     32'hDEADBEEF, 32'h12345678, 1'b0, 0,  32'h0,        1'b0, 1'b0, 1);
    vectors[1] = mkVec(1'b0, 32'd5,     32'h0,        32'hDEADBEEF, 1'b0, 3,  32'hDEADBEEF, 1'b0, 1'b0, 4);
    vectors[2] = mkVec(1'b0, 32'd40,    32'h0,        32'h00005555, 1'b1, 0,  32'h0,        1'b1, 1'b0, 1);
    vectors[3] = mkVec(1'b0, 32'h100,   32'h0,        32'hCAFEF00D, 1'b0, 15, 32'hCAFEF00D, 1'b0, 1'b0, 16);
    vectors[4] = mkVec(1'b0, 32'h104,   32'h0,        32'h0BADBEEF, 1'b0, 16, 32'h0,        1'b1, 1'b1, 16);
    vectors[5] = mkVec(1'b1, 32'h44,    32'hA5A5A5A5, 32'h11111111, 1'b1, 2,  32'h0,        1'b1, 1'b0, 3);
    vectors[6] = mkVec(1'b0, 32'h200,   32'h0,        32'h13572468, 1'b0, 40, 32'h0,        1'b1, 1'b1, 16);
    vectors[7] = mkVec(1'b1, 32'h300,   32'h0F0F0F0F, 32'h77777777, 1'b0, 1,  32'h0,        1'b0, 1'b0, 2);

    // Reset held two cycles with a command already offered.
    preset        = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_00AA;
    bus.cmd_wdata = 32'h5555_AAAA;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b1;
    bus.prdata    = 32'hFFFF_FFFF;
    @(negedge pclk);
    checkAllZero("reset0");
    @(negedge pclk);
    checkAllZero("reset1");
    preset = 1'b0;
    @(negedge pclk);
    checkOutput("postReset.cmdReady", {63'h0, bus.cmd_ready}, 64'h1);
    checkOutput("postReset.psel",     {63'h0, bus.psel}, 64'h0);
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    @(negedge pclk);
    checkOutput("postReset.noTransfer", {62'h0, bus.psel, bus.rsp_valid}, 64'h0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vectors[i], res);
      checkResult($sformatf("vec%0d", i), vectors[i], res);
    end

    for (int i = 0; i < 40; i++) begin
      bus.cmd_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge pclk);
      rv.write      = 1'($urandom_range(0, 1));
      rv.addr       = $urandom();
      rv.wdata      = $urandom();
      rv.prdata     = $urandom();
      rv.slvErr     = ($urandom_range(0, 3) == 0);
      rv.waitCycles = $urandom_range(0, TIMEOUT + 3);
      rv = modelExpect(rv);
      applyStimulus(rv, res);
      checkResult($sformatf("rand%0d", i), rv, res);
    end

    // Reset arriving while the slave is still stalling in ACCESS.
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h77;
    bus.cmd_wdata = 32'h0;
    bus.pready    = 1'b0;
    bus.cmd_valid = 1'b1;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    for (int t = 0; t < 5 && bus.penable !== 1'b1; t++) @(negedge pclk);
    checkOutput("midReset.inAccess", {63'h0, bus.penable}, 64'h1);
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    checkOutput("midReset.bus", {61'h0, bus.psel, bus.penable, bus.rsp_valid}, 64'h0);
    checkOutput("midReset.cmdReady", {63'h0, bus.cmd_ready}, 64'h0);
    preset     = 1'b0;
    bus.pready = 1'b1;
    rspCount   = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge pclk);
      if (bus.rsp_valid !== 1'b0) rspCount++;
    end
    checkOutput("midReset.noRsp", 64'(rspCount), 64'd0);
    bus.pready = 1'b0;
    rv = mkVec(1'b1, 32'h88, 32'h2468ACE0, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1'b0, 2);
    applyStimulus(rv, res);
    checkResult("afterReset", rv, res);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
